// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared core types, including active-list entry and FSM encodings.
package mips_core_pkg;
  typedef logic [5:0] PhysReg;
  localparam int ACTIVE_LIST_DEPTH = 32;
  typedef logic [$clog2(ACTIVE_LIST_DEPTH)-1:0] ActiveListTag;
  typedef struct packed {
    logic       valid;
    logic       done;
    logic [4:0] logical_reg;
    PhysReg     prev_preg;
    PhysReg     new_preg;
  } ActiveListEntry;
  typedef enum logic {AL_IDLE, AL_ROLLBACK} ActiveListState;
endpackage

// File: rtl/active_list.sv
// active_list: in-order retire buffer with serial youngest-first rollback on flush.
module active_list
  import mips_core_pkg::*;
#(
  parameter int DEPTH = ACTIVE_LIST_DEPTH,
  localparam int TW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  input  logic [4:0]    alloc_logical_reg,
  input  logic [5:0]    alloc_prev_preg,
  input  logic [5:0]    alloc_new_preg,
  output logic [TW-1:0] alloc_tag,
  input  logic          complete_valid,
  input  logic [TW-1:0] complete_tag,
  output logic          free_valid,
  output logic [5:0]    free_register,
  input  logic          flush,
  output logic          rollback_valid,
  output logic [4:0]    rollback_logical_reg,
  output logic [5:0]    rollback_prev_preg,
  output logic [5:0]    rollback_new_preg,
  output logic          rollback_done
);
  ActiveListState state, state_next;
  ActiveListEntry mem [DEPTH];
  logic [TW:0]   head, tail;
  logic [TW-1:0] head_idx, tail_idx, last_idx;
  logic          empty, full, do_alloc;
  assign head_idx = head[TW-1:0];
  assign tail_idx = tail[TW-1:0];
  assign last_idx = tail_idx - 1'b1;
  assign empty    = head == tail;
  assign full     = (head_idx == tail_idx) && (head[TW] != tail[TW]);
  assign do_alloc = alloc_valid && alloc_ready;
  assign alloc_tag = tail_idx;
  assign free_register = mem[head_idx].prev_preg;
  always_comb begin
    alloc_ready    = state == AL_IDLE && !full && !flush;
    free_valid     = state == AL_IDLE && !empty && mem[head_idx].done && !flush;
    rollback_valid = state == AL_ROLLBACK && !empty;
    rollback_done  = state == AL_ROLLBACK && empty;
    rollback_logical_reg = rollback_valid ? mem[last_idx].logical_reg : '0;
    rollback_prev_preg   = rollback_valid ? mem[last_idx].prev_preg : '0;
    rollback_new_preg    = rollback_valid ? mem[last_idx].new_preg : '0;
    state_next = state == AL_IDLE ? (flush ? AL_ROLLBACK : AL_IDLE)
                                  : (empty ? AL_IDLE : AL_ROLLBACK);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= AL_IDLE;
    else state <= state_next;
  end
  // Squash/retire clears are ordered after complete so a same-cycle complete cannot revive an entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (complete_valid && mem[complete_tag].valid) mem[complete_tag].done <= 1'b1;
      if (do_alloc) begin
        mem[tail_idx] <= '{valid: 1'b1, done: 1'b0, logical_reg: alloc_logical_reg,
                           prev_preg: alloc_prev_preg, new_preg: alloc_new_preg};
        tail <= tail + 1'b1;
      end
      if (free_valid) begin
        mem[head_idx].valid <= 1'b0;
        mem[head_idx].done  <= 1'b0;
        head <= head + 1'b1;
      end
      if (rollback_valid) begin
        mem[last_idx].valid <= 1'b0;
        mem[last_idx].done  <= 1'b0;
        tail <= tail - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_active_list.sv
// tb_active_list: scoreboard bench; in-flight entries queued at alloc, popped at retire (front) or rollback (back).
module tb_active_list;
  logic clk = 0, rst_n = 0;
  logic alloc_valid = 0, complete_valid = 0, flush = 0;
  logic alloc_ready, free_valid, rollback_valid, rollback_done;
  logic [4:0] alloc_logical_reg = 0, alloc_tag, complete_tag = 0, rollback_logical_reg;
  logic [5:0] alloc_prev_preg = 0, alloc_new_preg = 0, free_register, rollback_prev_preg, rollback_new_preg;
  typedef struct {
    logic [4:0] lr;
    logic [5:0] pp;
    logic [5:0] np;
  } ent_t;
  ent_t q[$];
  ent_t e;
  logic [4:0] exp_tail = 0;
  int n_pass = 0, n_total = 0;

  active_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_logical_reg(alloc_logical_reg), .alloc_prev_preg(alloc_prev_preg),
    .alloc_new_preg(alloc_new_preg), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag),
    .free_valid(free_valid), .free_register(free_register),
    .flush(flush), .rollback_valid(rollback_valid),
    .rollback_logical_reg(rollback_logical_reg), .rollback_prev_preg(rollback_prev_preg),
    .rollback_new_preg(rollback_new_preg), .rollback_done(rollback_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic half();
    @(negedge clk);
    if (alloc_valid && alloc_ready) begin
      check("alloc_tag", alloc_tag, exp_tail);
      q.push_back('{alloc_logical_reg, alloc_prev_preg, alloc_new_preg});
      exp_tail++;
    end
    if (free_valid) begin
      if (q.size() == 0) check("free_unexpected", free_valid, 0);
      else begin
        e = q.pop_front();
        check("free_register", free_register, e.pp);
      end
    end
    if (rollback_valid) begin
      if (q.size() == 0) check("rollback_unexpected", rollback_valid, 0);
      else begin
        e = q.pop_back();
        check("rb_logical", rollback_logical_reg, e.lr);
        check("rb_prev", rollback_prev_preg, e.pp);
        check("rb_new", rollback_new_preg, e.np);
        exp_tail--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    step();
  endtask

  task automatic do_reset();
    alloc_valid = 0; complete_valid = 0; flush = 0;
    rst_n = 0;
    q.delete();
    exp_tail = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic alloc(input logic [4:0] lr, input logic [5:0] pp, input logic [5:0] np);
    alloc_valid = 1; alloc_logical_reg = lr; alloc_prev_preg = pp; alloc_new_preg = np;
    cyc();
    alloc_valid = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_ready"}, alloc_ready, 1);
    check({tag, "_alloc_tag"}, alloc_tag, 0);
    check({tag, "_free_valid"}, free_valid, 0);
    check({tag, "_free_register"}, free_register, 0);
    check({tag, "_rb_valid"}, rollback_valid, 0);
    check({tag, "_rb_lr"}, rollback_logical_reg, 0);
    check({tag, "_rb_pp"}, rollback_prev_preg, 0);
    check({tag, "_rb_np"}, rollback_new_preg, 0);
    check({tag, "_rb_done"}, rollback_done, 0);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    step();

    // single alloc, complete, retire next cycle
    alloc(5'd5, 6'd5, 6'd32);
    complete_valid = 1; complete_tag = 0;
    half(); check("t1_same_cycle_free", free_valid, 0); step();
    complete_valid = 0;
    half(); check("t1_free_valid", free_valid, 1); check("t1_free_reg", free_register, 5); step();
    half(); check("t1_empty_free", free_valid, 0); step();

    // in-order retire with out-of-order completion
    do_reset();
    alloc(5'd1, 6'd1, 6'd33);
    alloc(5'd2, 6'd2, 6'd34);
    alloc(5'd3, 6'd3, 6'd35);
    complete_valid = 1; complete_tag = 2;
    half(); check("t2_c2_free", free_valid, 0); step();
    complete_tag = 0;
    half(); check("t2_c0_free", free_valid, 0); step();
    complete_valid = 0;
    half(); check("t2_tag0_retire", free_valid, 1); step();
    for (int i = 0; i < 2; i++) begin
      half(); check("t2_tag2_waits", free_valid, 0); step();
    end
    complete_valid = 1; complete_tag = 1;
    half(); check("t2_c1_free", free_valid, 0); step();
    complete_valid = 0;
    half(); check("t2_tag1_retire", free_valid, 1); step();
    half(); check("t2_tag2_retire", free_valid, 1); step();
    half(); check("t2_drained", free_valid, 0); check("t2_q_empty", q.size(), 0); step();

    // fill, no bypass on full, wrap
    do_reset();
    for (int i = 0; i < 32; i++) alloc(5'(i), 6'(i), 6'(i + 32));
    alloc_valid = 1; alloc_logical_reg = 9; alloc_prev_preg = 9; alloc_new_preg = 9;
    half(); check("t3_full_ready", alloc_ready, 0); step();
    complete_valid = 1; complete_tag = 0;
    half(); check("t3_full_ready2", alloc_ready, 0); step();
    complete_valid = 0;
    half(); check("t3_free_valid", free_valid, 1); check("t3_no_bypass", alloc_ready, 0); step();
    half(); check("t3_ready_after", alloc_ready, 1); check("t3_wrap_tag", alloc_tag, 0); step();
    alloc_valid = 0;
    half(); check("t3_full_again", alloc_ready, 0); step();

    // flush with two entries: youngest-first rollback
    do_reset();
    alloc(5'd3, 6'd3, 6'd40);
    alloc(5'd4, 6'd4, 6'd41);
    flush = 1; alloc_valid = 1; alloc_logical_reg = 7; alloc_prev_preg = 7; alloc_new_preg = 7;
    half(); check("t4_flush_ready", alloc_ready, 0); check("t4_flush_rbv", rollback_valid, 0); step();
    flush = 0; alloc_valid = 0; complete_valid = 1; complete_tag = 1;
    half(); check("t4_rb1_valid", rollback_valid, 1); check("t4_rb1_lr", rollback_logical_reg, 4);
    check("t4_rb1_np", rollback_new_preg, 41); step();
    complete_valid = 0;
    half(); check("t4_rb2_valid", rollback_valid, 1); check("t4_rb2_lr", rollback_logical_reg, 3);
    check("t4_rb2_np", rollback_new_preg, 40); step();
    half(); check("t4_done", rollback_done, 1); check("t4_done_rbv", rollback_valid, 0);
    check("t4_done_ready", alloc_ready, 0); step();
    half(); check("t4_done_pulse", rollback_done, 0); check("t4_ready", alloc_ready, 1);
    check("t4_q_empty", q.size(), 0); step();
    alloc(5'd8, 6'd8, 6'd50);
    half(); check("t4_no_stale_done", free_valid, 0); step();

    // flush on empty list
    do_reset();
    flush = 1;
    half(); check("t5_flush_done", rollback_done, 0); step();
    flush = 0;
    half(); check("t5_done", rollback_done, 1); check("t5_rbv", rollback_valid, 0); step();
    half(); check("t5_done_pulse", rollback_done, 0); check("t5_ready", alloc_ready, 1); step();

    // reset mid-rollback abandons without done pulse
    alloc(5'd1, 6'd11, 6'd21);
    alloc(5'd2, 6'd12, 6'd22);
    alloc(5'd3, 6'd13, 6'd23);
    flush = 1; cyc(); flush = 0;
    cyc();
    rst_n = 0;
    #1;
    check_reset_outputs("midrb");
    q.delete(); exp_tail = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      half(); check("t6_no_done", rollback_done, 0); check("t6_no_rbv", rollback_valid, 0); step();
    end
    alloc(5'd6, 6'd6, 6'd60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=finish", n_total);
    $fatal(1);
  end
endmodule

// File: doc/active_list.md
ACTIVE_LIST -- requirements
Module: active_list

Interface
REQ-001 Parameter DEPTH, default 32, number of in-flight entries; power of two.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 alloc_valid  input  1  rename stage presents a renamed destination this cycle.
REQ-005 alloc_ready  output  1  entry can be accepted this cycle.
REQ-006 alloc_logical_reg  input  5  architectural destination register (prev_logical_reg from rename).
REQ-007 alloc_prev_preg  input  6  physical register previously mapped to that destination (prev_physical_reg).
REQ-008 alloc_new_preg  input  6  physical register newly allocated by rename.
REQ-009 alloc_tag  output  log2(DEPTH)  index assigned to the accepted entry (tail pointer).
REQ-010 complete_valid  input  1  execution finished for complete_tag.
REQ-011 complete_tag  input  log2(DEPTH)  entry index being marked done.
REQ-012 free_valid  output  1  oldest entry retires this cycle.
REQ-013 free_register  output  6  physical register returned to the free list (retired entry's prev_preg).
REQ-014 flush  input  1  squash all uncommitted entries (mispredict/exception).
REQ-015 rollback_valid  output  1  one youngest entry being undone this cycle.
REQ-016 rollback_logical_reg  output  5  map-table index to restore.
REQ-017 rollback_prev_preg  output  6  mapping to restore into map table.
REQ-018 rollback_new_preg  output  6  squashed physical register to return to free list.
REQ-019 rollback_done  output  1  single-cycle pulse: rollback complete, list empty.

Function
REQ-020 Storage SHALL be a circular buffer: head (oldest), tail (next free), each with an extra wrap bit; empty = pointers equal, full = indices equal and wrap bits differ.
REQ-021 Each entry SHALL hold valid, done, logical_reg, prev_preg, new_preg.
REQ-022 FSM SHALL have states IDLE and ROLLBACK; reset state IDLE.
REQ-023 alloc_ready SHALL equal (state==IDLE) && !full && !flush; no full-list bypass even if a commit occurs same cycle.
REQ-024 On alloc_valid && alloc_ready the entry at tail SHALL be written with valid=1, done=0 and tail SHALL increment (wrap at DEPTH); alloc_tag = tail index, combinational.
REQ-025 complete_valid SHALL set done on complete_tag only if that entry is valid; otherwise ignored.
REQ-026 free_valid SHALL be combinational: state==IDLE && !empty && head entry done && !flush; free_register = head prev_preg; on that edge head entry valid clears and head increments; at most one retire per cycle.
REQ-027 Alloc, complete and retire in the same cycle SHALL all take effect; complete of the head entry is visible for retire the following cycle, not the same cycle.
REQ-028 flush in IDLE SHALL move state to ROLLBACK next edge; alloc and retire are suppressed in the flush cycle; flush in ROLLBACK is ignored.
REQ-029 In ROLLBACK, if not empty, rollback_valid=1 with fields of entry tail-1; on the edge tail decrements and that entry's valid clears; one entry per cycle, youngest first.
REQ-030 In ROLLBACK, if empty, rollback_done=1 for that cycle and state returns to IDLE next edge; flush with empty list thus yields rollback_done one cycle after flush.
REQ-031 complete_valid during ROLLBACK SHALL be ignored for entries already squashed and otherwise harmless.

Reset
REQ-032 On rst_n low: state IDLE, head=tail=0 with wrap bits 0, all entry valid/done=0; asynchronously.
REQ-033 Reset values: alloc_ready=1, alloc_tag=0, free_valid=0, free_register=0, rollback_valid=0, rollback_*_reg/preg=0, rollback_done=0.
REQ-034 Reset asserted mid-ROLLBACK SHALL abandon rollback without a rollback_done pulse.

Structure
REQ-035 mips_core_pkg SHALL gain PhysReg (6-bit) typedef, ACTIVE_LIST_DEPTH constant, ActiveListTag typedef and the entry struct.
REQ-036 No sub-module; storage, pointers and FSM are inline in active_list.

Verification
REQ-037 Alloc (r5, prev 5, new 32), complete tag 0 -> next cycle free_valid=1, free_register=5.
REQ-038 Alloc tags 0,1,2; complete 2 then 0 -> only tag 0 retires; tag 2 waits until tag 1 completes; in-order retire.
REQ-039 Fill 32 entries -> alloc_ready=0; retire one -> alloc_ready=1 next cycle; tail wraps to index 0.
REQ-040 Alloc r3(prev 3,new 40), r4(prev 4,new 41), flush -> rollback r4/4/41 then r3/3/40, then rollback_done pulse, alloc_ready=1.
REQ-041 Flush on empty list -> rollback_done one cycle later, no rollback_valid; rst_n low mid-rollback -> all outputs at reset values.
